// File: rtl/fp32_to_int_seq.sv
// IEEE-754 single fields -> signed INT_W integer, truncating toward zero, one alignment bit per clock.
// Latency 1 for special cases, k+2 on the normal path; result held in DONE until out_ready, in_ready only in IDLE.
module fp32_to_int_seq #(
  parameter int INT_W = 32,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [7:0]       exp_in,
  input  logic [22:0]      man_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] int_out,
  output logic             overflow,
  output logic             inexact
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SIGN  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [9:0] BIAS_W = 10'(BIAS);
  localparam logic [9:0] TOP_E  = 10'(INT_W - 1);
  localparam logic [9:0] MAN_E  = 10'd23;

  localparam logic [INT_W-1:0] MAX_V = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_V = {1'b1, {(INT_W-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic             left_q, left_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [INT_W:0]   mag_q, mag_d;
  logic [INT_W-1:0] int_q, int_d;
  logic             ovf_q, ovf_d;
  logic             inx_q, inx_d;

  // Unbiased exponent in 10-bit two's complement; bit 9 is the sign.
  logic [9:0] e10;
  logic [9:0] kdiff;
  logic       e_neg;

  assign e10   = {2'b00, exp_in} - BIAS_W;
  assign e_neg = e10[9];
  assign kdiff = (e10 > MAN_E) ? (e10 - MAN_E) : (MAN_E - e10);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    int_d   = int_q;
    ovf_d   = ovf_q;
    inx_d   = inx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          ovf_d  = 1'b0;
          inx_d  = 1'b0;
          int_d  = '0;
          mag_d  = '0;
          if (exp_in == 8'hFF) begin
            ovf_d   = 1'b1;
            int_d   = sign_in ? MIN_V : MAX_V;
            state_d = S_DONE;
          end else if (exp_in == 8'h00) begin
            inx_d   = |man_in;
            state_d = S_DONE;
          end else if (e_neg) begin
            inx_d   = 1'b1;
            state_d = S_DONE;
          end else if (e10 >= TOP_E) begin
            // -2^(INT_W-1) is exactly representable; everything else up here saturates.
            if (sign_in && (e10 == TOP_E) && (man_in == 23'd0)) begin
              int_d = MIN_V;
            end else begin
              ovf_d = 1'b1;
              int_d = sign_in ? MIN_V : MAX_V;
            end
            state_d = S_DONE;
          end else begin
            mag_d   = {{(INT_W-23){1'b0}}, 1'b1, man_in};
            left_d  = (e10 > MAN_E);
            cnt_d   = kdiff;
            state_d = (kdiff == 10'd0) ? S_SIGN : S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d = mag_q >> 1;
          inx_d = inx_q | mag_q[0];
        end
        cnt_d = cnt_q - 10'd1;
        if (cnt_q == 10'd1) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        int_d   = sign_q ? -mag_q[INT_W-1:0] : mag_q[INT_W-1:0];
        state_d = S_DONE;
      end
      default: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      mag_q   <= '0;
      int_q   <= '0;
      ovf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
      inx_q   <= inx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign int_out   = int_q;
  assign overflow  = ovf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp32_to_int_seq.sv
// Directed-vector bench for fp32_to_int_seq with INT_W=32, BIAS=127.
module tb_fp32_to_int_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [22:0] man_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        overflow;
  logic        inexact;

  int n_checks = 0;
  int n_fail   = 0;

  fp32_to_int_seq #(.INT_W(32), .BIAS(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .man_in    (man_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  // Drives one conversion with out_ready high; lat = -1 if no result within 100 cycles.
  task automatic run_conv(input logic s, input logic [7:0] e, input logic [22:0] m,
                          output int lat, output logic [31:0] res,
                          output logic ovf, output logic inx);
    int guard;
    @(negedge clk);
    sign_in   = s;
    exp_in    = e;
    man_in    = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    res = int_out;
    ovf = overflow;
    inx = inexact;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sign_in = 1'b0;
    exp_in = 8'd0;
    man_in = 23'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, int_out, overflow, inexact} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b int=%h ovf=%b inx=%b want rdy=1 vld=0 int=0 ovf=0 inx=0",
               in_ready, out_valid, int_out, overflow, inexact);
    end
  endtask

  task automatic test_normal();
    logic        vs [7];
    logic [7:0]  ve [7];
    logic [22:0] vm [7];
    logic [31:0] xr [7];
    logic        xi [7];
    int          xl [7];
    int lat;
    logic [31:0] res;
    logic ovf, inx;
    vs[0]=0; ve[0]=127; vm[0]=23'h000000; xr[0]=32'h00000001; xi[0]=0; xl[0]=25;
    vs[1]=1; ve[1]=129; vm[1]=23'h380000; xr[1]=32'hFFFFFFFB; xi[1]=1; xl[1]=23;
    vs[2]=0; ve[2]=157; vm[2]=23'h000000; xr[2]=32'h40000000; xi[2]=0; xl[2]=9;
    vs[3]=0; ve[3]=150; vm[3]=23'h000000; xr[3]=32'h00800000; xi[3]=0; xl[3]=2;
    vs[4]=1; ve[4]=157; vm[4]=23'h7FFFFF; xr[4]=32'h80000080; xi[4]=0; xl[4]=9;
    vs[5]=0; ve[5]=140; vm[5]=23'h123456; xr[5]=32'h0000248D; xi[5]=1; xl[5]=12;
    vs[6]=0; ve[6]=151; vm[6]=23'h400000; xr[6]=32'h01800000; xi[6]=0; xl[6]=3;
    for (int i = 0; i < 7; i++) begin
      run_conv(vs[i], ve[i], vm[i], lat, res, ovf, inx);
      n_checks++;
      if ({res, ovf, inx} !== {xr[i], 1'b0, xi[i]}) begin
        n_fail++;
        $display("FAIL normal_value[%0d]: got int=%h ovf=%b inx=%b want int=%h ovf=0 inx=%b",
                 i, res, ovf, inx, xr[i], xi[i]);
      end
      n_checks++;
      if (lat !== xl[i]) begin
        n_fail++;
        $display("FAIL normal_latency[%0d]: got %0d want %0d", i, lat, xl[i]);
      end
    end
  endtask

  task automatic test_special();
    logic        vs [9];
    logic [7:0]  ve [9];
    logic [22:0] vm [9];
    logic [31:0] xr [9];
    logic        xo [9];
    logic        xi [9];
    int lat;
    logic [31:0] res;
    logic ovf, inx;
    vs[0]=0; ve[0]=158; vm[0]=23'h0;      xr[0]=32'h7FFFFFFF; xo[0]=1; xi[0]=0;
    vs[1]=1; ve[1]=158; vm[1]=23'h0;      xr[1]=32'h80000000; xo[1]=0; xi[1]=0;
    vs[2]=0; ve[2]=255; vm[2]=23'h400000; xr[2]=32'h7FFFFFFF; xo[2]=1; xi[2]=0;
    vs[3]=1; ve[3]=255; vm[3]=23'h0;      xr[3]=32'h80000000; xo[3]=1; xi[3]=0;
    vs[4]=0; ve[4]=126; vm[4]=23'h0;      xr[4]=32'h00000000; xo[4]=0; xi[4]=1;
    vs[5]=0; ve[5]=0;   vm[5]=23'h0;      xr[5]=32'h00000000; xo[5]=0; xi[5]=0;
    vs[6]=1; ve[6]=0;   vm[6]=23'h000001; xr[6]=32'h00000000; xo[6]=0; xi[6]=1;
    vs[7]=1; ve[7]=158; vm[7]=23'h000001; xr[7]=32'h80000000; xo[7]=1; xi[7]=0;
    vs[8]=0; ve[8]=200; vm[8]=23'h000005; xr[8]=32'h7FFFFFFF; xo[8]=1; xi[8]=0;
    for (int i = 0; i < 9; i++) begin
      run_conv(vs[i], ve[i], vm[i], lat, res, ovf, inx);
      n_checks++;
      if ({res, ovf, inx} !== {xr[i], xo[i], xi[i]}) begin
        n_fail++;
        $display("FAIL special_value[%0d]: got int=%h ovf=%b inx=%b want int=%h ovf=%b inx=%b",
                 i, res, ovf, inx, xr[i], xo[i], xi[i]);
      end
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL special_latency[%0d]: got %0d want 1", i, lat);
      end
    end
  endtask

  task automatic test_hold();
    int guard;
    @(negedge clk);
    sign_in = 1'b1; exp_in = 8'd129; man_in = 23'h380000;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 100);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, int_out, overflow, inexact} !== {1'b1, 1'b0, 32'hFFFFFFFB, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b int=%h ovf=%b inx=%b want vld=1 rdy=0 int=fffffffb ovf=0 inx=1",
                 i, out_valid, in_ready, int_out, overflow, inexact);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midshift();
    logic seen;
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'd127; man_in = 23'h0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, int_out} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_midshift: got rdy=%b vld=%b int=%h want rdy=1 vld=0 int=0",
               in_ready, out_valid, int_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dropped: got out_valid=%b after reset want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    int lat;
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'd150; man_in = 23'h0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 exp_in = 8'd151;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 100);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, int_out} !== {1'b1, 1'b0, 32'h00800000}) begin
      n_fail++;
      $display("FAIL b2b_first: got vld=%b rdy=%b int=%h want vld=1 rdy=0 int=00800000",
               out_valid, in_ready, int_out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_gap: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if ({lat, int_out, overflow, inexact} !== {32'sd3, 32'h01000000, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d int=%h ovf=%b inx=%b want lat=3 int=01000000 ovf=0 inx=0",
               lat, int_out, overflow, inexact);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_hold();
    test_reset_midshift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
